// File: rtl/tmp8_control_unit.sv
// TMP8 control unit: multi-cycle fetch/decode/execute sequencer.
// Drives every load enable, source select and memory strobe of the 8-bit datapath.
// A memory state that waits too long for mem_ready_i parks the machine in HALT with a sticky fault.
module tmp8_control_unit #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_flag_i,
  input  logic       carry_flag_i,
  input  logic       mem_ready_i,
  output logic       pc_inc_o,
  output logic       pc_load_o,
  output logic       mar_sel_o,
  output logic       mar_load_o,
  output logic       ir_load_o,
  output logic       a_load_o,
  output logic [1:0] a_sel_o,
  output logic       b_load_o,
  output logic       alu_sub_o,
  output logic       flags_load_o,
  output logic       out_load_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       halted_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_ADDR = 3'd1,
    F_MEM  = 3'd2,
    DECODE = 3'd3,
    X_ADDR = 3'd4,
    X_MEM  = 3'd5,
    X_WB   = 3'd6,
    HALT   = 3'd7
  } stateT;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJz  = 4'h7;
  localparam logic [3:0] OpJc  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  // Last wait count at which a missing mem_ready_i still counts as a timeout.
  localparam logic [3:0] LimitM1 = 4'(WAIT_LIMIT - 1);

  // A-register source select encodings.
  localparam logic [1:0] ASelMem = 2'd0;
  localparam logic [1:0] ASelAlu = 2'd1;
  localparam logic [1:0] ASelImm = 2'd2;

  stateT      state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic       fault_q, fault_d;

  // State, wait counter and sticky fault register; reset returns to a clean IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state and per-state strobe decode; anything not asserted for a state stays 0.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    fault_d      = fault_q;
    pc_inc_o     = 1'b0;
    pc_load_o    = 1'b0;
    mar_sel_o    = 1'b0;
    mar_load_o   = 1'b0;
    ir_load_o    = 1'b0;
    a_load_o     = 1'b0;
    a_sel_o      = ASelMem;
    b_load_o     = 1'b0;
    alu_sub_o    = 1'b0;
    flags_load_o = 1'b0;
    out_load_o   = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    halted_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d = F_ADDR;
        end
      end

      F_ADDR: begin
        mar_sel_o  = 1'b0;
        mar_load_o = 1'b1;
        waitCnt_d  = 4'd0;
        state_d    = F_MEM;
      end

      F_MEM: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_load_o = 1'b1;
          pc_inc_o  = 1'b1;
          state_d   = DECODE;
        end else if (waitCnt_q == LimitM1) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end

      DECODE: begin
        state_d = F_ADDR;
        case (opcode_i)
          OpLda, OpAdd, OpSub, OpSta: state_d = X_ADDR;
          OpLdi: begin
            a_load_o = 1'b1;
            a_sel_o  = ASelImm;
          end
          OpJmp:   pc_load_o  = 1'b1;
          OpJz:    pc_load_o  = zero_flag_i;
          OpJc:    pc_load_o  = carry_flag_i;
          OpOut:   out_load_o = 1'b1;
          OpHlt:   state_d    = HALT;
          OpNop:   state_d    = F_ADDR;
          default: state_d    = F_ADDR;
        endcase
      end

      X_ADDR: begin
        mar_sel_o  = 1'b1;
        mar_load_o = 1'b1;
        waitCnt_d  = 4'd0;
        state_d    = X_MEM;
      end

      X_MEM: begin
        if (opcode_i == OpSta) begin
          mem_wr_o = 1'b1;
        end else begin
          mem_rd_o = 1'b1;
        end
        if (mem_ready_i) begin
          case (opcode_i)
            OpLda: begin
              a_load_o = 1'b1;
              a_sel_o  = ASelMem;
              state_d  = F_ADDR;
            end
            OpAdd, OpSub: begin
              b_load_o = 1'b1;
              state_d  = X_WB;
            end
            default: state_d = F_ADDR;
          endcase
        end else if (waitCnt_q == LimitM1) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end

      X_WB: begin
        a_load_o     = 1'b1;
        a_sel_o      = ASelAlu;
        flags_load_o = 1'b1;
        alu_sub_o    = (opcode_i == OpSub);
        state_d      = F_ADDR;
      end

      HALT: begin
        halted_o = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign fault_o = fault_q;
  assign state_o = state_q;

endmodule

// File: doc/tmp8_control_unit.md
# tmp8_control_unit

Multi-cycle fetch/decode/execute sequencer for the TMP8 datapath. It drives the load enables and source selects of the 8-bit datapath registers (PC, MAR, IR, A, B, FLAGS, OUT) and the memory strobes, one strobe set per state. It sits directly upstream of the register stage: every register `enable` in the datapath comes from this block. It consumes the IR opcode nibble, the ALU flags and a memory ready handshake.

## Interface
- WAIT_LIMIT, 15: max consecutive cycles a memory state waits for `mem_ready` before faulting (1..15).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising `clk`.
- run  in  1  start request; honoured only in IDLE.
- opcode  in  4  IR[7:4]; valid from DECODE onward.
- zero_flag  in  1  FLAGS.Z.
- carry_flag  in  1  FLAGS.C.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= IR[3:0].
- mar_sel  out  1  MAR source: 0 = PC, 1 = IR[3:0].
- mar_load  out  1  MAR enable.
- ir_load  out  1  IR enable (from memory data).
- a_load  out  1  A enable.
- a_sel  out  2  A source: 0 = memory data, 1 = ALU result, 2 = IR[3:0] zero-extended.
- b_load  out  1  B enable (from memory data).
- alu_sub  out  1  ALU op: 0 = A+B, 1 = A-B.
- flags_load  out  1  FLAGS enable.
- out_load  out  1  OUT register enable (from A).
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe (data = A).
- halted  out  1  high in HALT.
- fault  out  1  sticky; set on memory timeout.
- state  out  3  current state code (debug).

## Operation
- States: IDLE=0, F_ADDR=1, F_MEM=2, DECODE=3, X_ADDR=4, X_MEM=5, X_WB=6, HALT=7.
- All outputs are decoded combinationally from the registered state plus `opcode`/flags/`mem_ready`. Every output not listed for a state is 0. `a_sel`, `mar_sel` are 0 when not used.
- IDLE: `run`=1 -> F_ADDR, else stay.
- F_ADDR: `mar_sel`=0, `mar_load`=1 -> F_MEM.
- F_MEM: `mem_rd`=1. If `mem_ready`, then `ir_load`=1, `pc_inc`=1 -> DECODE. Otherwise stay.
- DECODE, by opcode:
  - 0x0 NOP and undefined codes (0x9-0xD) -> F_ADDR.
  - 0x1 LDA, 0x2 ADD, 0x3 SUB, 0x4 STA -> X_ADDR.
  - 0x5 LDI: `a_load`=1, `a_sel`=2 -> F_ADDR.
  - 0x6 JMP: `pc_load`=1 -> F_ADDR.
  - 0x7 JZ: `pc_load`=`zero_flag` -> F_ADDR.
  - 0x8 JC: `pc_load`=`carry_flag` -> F_ADDR.
  - 0xE OUT: `out_load`=1 -> F_ADDR.
  - 0xF HLT -> HALT.
- X_ADDR: `mar_sel`=1, `mar_load`=1 -> X_MEM.
- X_MEM: STA drives `mem_wr`=1; the other opcodes drive `mem_rd`=1. On `mem_ready`:
  - LDA: `a_load`=1, `a_sel`=0 -> F_ADDR.
  - ADD/SUB: `b_load`=1 -> X_WB.
  - STA -> F_ADDR.
  - Without `mem_ready`, stay.
- X_WB: `a_load`=1, `a_sel`=1, `flags_load`=1, `alu_sub`=(opcode==0x3) -> F_ADDR.
- HALT: `halted`=1. Leaves only on `reset`; `run` is ignored.
- Wait counter (4-bit): cleared on entry to F_MEM/X_MEM and increments each cycle in that state without `mem_ready`.
  - If the counter equals WAIT_LIMIT-1 and `mem_ready`=0, go to HALT and set `fault`.
  - `mem_ready` in the limit cycle wins: normal completion, no fault.

## Timing
- Reset: next edge gives state=IDLE, wait counter=0, `fault`=0. All outputs are then 0, `state`=0.
- Reset mid-operation (including during `mem_rd`/`mem_wr` wait): strobes drop at the first edge with `reset`=1. No partial register load follows.
- `run` held high in IDLE: F_ADDR on the next edge. `run` pulses outside IDLE are lost.
- Instruction latency with zero-wait memory (`mem_ready` tied 1):
  - NOP/LDI/JMP/JZ/JC/OUT/HLT: 3 cycles.
  - LDA/STA: 5 cycles.
  - ADD/SUB: 6 cycles.
  - Each wait cycle adds 1.
- `opcode` is read only in DECODE, X_MEM and X_WB. IR loads at the edge leaving F_MEM, so the opcode is stable throughout.
- Flags are sampled in DECODE only. The FLAGS update from X_WB is visible to a branch decoded ≥3 cycles later.
- Memory strobes stay asserted continuously while waiting and drop in the cycle after `mem_ready`.

## Test plan
- Reset/idle: `reset` 1 cycle, `run`=0 for 10 cycles -> `state`=0, all strobes 0, `halted`=0, `fault`=0.
- LDI+OUT+HLT, zero-wait: opcodes 0x5,0xE,0xF after `run` pulse.
  - Required trace: states 1,2,3 ×3, then 7.
  - Exactly one `a_load` with `a_sel`=2, one `out_load`, `halted`=1 at cycle 10.
- ADD with 2 wait cycles in X_MEM: opcode 0x2.
  - Required: `mem_rd` high 3 cycles in X_MEM, `b_load` in the 3rd.
  - X_WB follows with `a_load`=1, `a_sel`=1, `flags_load`=1, `alu_sub`=0. Instruction totals 8 cycles.
- Branches: JZ with `zero_flag`=0 -> no `pc_load`. JZ with `zero_flag`=1 -> `pc_load`=1 in DECODE. JC same with `carry_flag`. Opcode 0xA -> behaves as NOP.
- Timeout: WAIT_LIMIT=4, `mem_ready`=0 in F_MEM.
  - Required: HALT after 4 F_MEM cycles, `fault`=1, `halted`=1.
  - Repeat with `mem_ready`=1 in the 4th cycle -> DECODE, `fault`=0.
- Reset during STA wait: assert `reset` on the 2nd X_MEM cycle -> `mem_wr`=0 and `state`=0 after the edge, `fault`=0. A subsequent `run` restarts a fetch.
